// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer sharing one external NAND SR latch among NREQ requesters.
// Drives registered active-low set/reset pulses, waits to settle, then verifies q feedback.
module sr_latch_ctrl #(
    parameter int NREQ          = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] ack,
    output logic            s_n,
    output logic            r_n,
    input  logic            q_fb,
    output logic            flag,
    output logic            busy,
    output logic            err
);

    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] LAST_IDX    = GW'(NREQ - 1);
    localparam logic [GW:0]   NREQ_EXT    = (GW + 1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [GW-1:0]   gidx, gidx_nxt;
    logic [GW-1:0]   rr, rr_nxt;
    logic            op_g, op_g_nxt;
    logic [1:0]      q_sync;
    logic            s_n_nxt, r_n_nxt;
    logic [NREQ-1:0] ack_nxt;
    logic            flag_nxt, err_nxt;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [GW-1:0]     win_off;
    logic [GW:0]       win_sum;
    logic [GW-1:0]     win_idx;
    logic              any_req;

    // Rotate requests so the rr pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> rr;
        req_rot = req_dbl[NREQ-1:0];
        win_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = GW'(i);
            end
        end
        win_sum = {1'b0, rr} + {1'b0, win_off};
        if (win_sum >= NREQ_EXT) begin
            win_sum = win_sum - NREQ_EXT;
        end
        win_idx = win_sum[GW-1:0];
        any_req = |req;
    end

    // Latch drive values are computed for the next state, so s_n/r_n come straight from flops.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        gidx_nxt  = gidx;
        op_g_nxt  = op_g;
        rr_nxt    = rr;
        s_n_nxt   = 1'b1;
        r_n_nxt   = 1'b1;
        ack_nxt   = '0;
        flag_nxt  = flag;
        err_nxt   = err;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (any_req) begin
                    state_nxt = PULSE;
                    gidx_nxt  = win_idx;
                    op_g_nxt  = op[win_idx];
                    s_n_nxt   = ~op[win_idx];
                    r_n_nxt   = op[win_idx];
                end
            end
            PULSE: begin
                s_n_nxt = ~op_g;
                r_n_nxt = op_g;
                if (cnt == PULSE_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    s_n_nxt   = 1'b1;
                    r_n_nxt   = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt     = CHECK;
                    cnt_nxt       = '0;
                    ack_nxt[gidx] = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                flag_nxt  = op_g;
                if (q_sync[1] != op_g) begin
                    err_nxt = 1'b1;
                end
                rr_nxt = (gidx == LAST_IDX) ? '0 : gidx + GW'(1);
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            gidx   <= '0;
            rr     <= '0;
            op_g   <= 1'b0;
            q_sync <= '0;
            s_n    <= 1'b1;
            r_n    <= 1'b1;
            ack    <= '0;
            flag   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gidx   <= gidx_nxt;
            rr     <= rr_nxt;
            op_g   <= op_g_nxt;
            q_sync <= {q_sync[0], q_fb};
            s_n    <= s_n_nxt;
            r_n    <= r_n_nxt;
            ack    <= ack_nxt;
            flag   <= flag_nxt;
            err    <= err_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
